// File: rtl/ls_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM
// state encoding and small helpers for decoding the funct3 field.
package ls_pkg;

  // funct3 codes (loads use all five, stores use LS_B/LS_H/LS_W)
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  // op = {is_store, funct3}
  localparam int OP_ST_BIT = 3;

  // mem_len encoding is bytes-1
  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } ls_state_e;

  // Access length for an op; anything not defined for the op kind is a word.
  function automatic logic [1:0] acc_len(input logic is_store, input logic [2:0] f3);
    logic [1:0] len;
    len = LEN_W;
    case (f3)
      LS_B:    len = LEN_B;
      LS_H:    len = LEN_H;
      LS_BU:   len = is_store ? LEN_W : LEN_B;
      LS_HU:   len = is_store ? LEN_W : LEN_H;
      default: len = LEN_W;
    endcase
    return len;
  endfunction

  // Zero-extending funct3 matching an access length; used to mask store data.
  function automatic logic [2:0] len_to_zext(input logic [1:0] len);
    logic [2:0] f3;
    case (len)
      LEN_B:   f3 = LS_BU;
      LEN_H:   f3 = LS_HU;
      default: f3 = LS_W;
    endcase
    return f3;
  endfunction

endpackage

// File: rtl/ls_unit_extend.sv
// Combinational sign/zero extension of right-aligned data by funct3.
// Undefined funct3 values pass the data through as a full word.
module ls_unit_extend
  import ls_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] result
);

  // Select extension based on access size and signedness
  always_comb begin
    result = raw;
    case (funct3)
      LS_B:    result = {{(XLEN-8){raw[7]}}, raw[7:0]};
      LS_H:    result = {{(XLEN-16){raw[15]}}, raw[15:0]};
      LS_BU:   result = {{(XLEN-8){1'b0}}, raw[7:0]};
      LS_HU:   result = {{(XLEN-16){1'b0}}, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/ls_unit.sv
// Load/store execution unit: one op at a time, single-port memory
// request/wait handshake, CDB broadcast for loads, ROB completion for stores.
// Optional build macro MISALIGN_TRAP_EN adds misalignment trapping ports.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | ready for a new op from the LS buffer
// ST_REQ   | op latched, waiting for mem_free to issue the strobe
// ST_WAIT  | request issued, waiting for mem_done
// ST_RESP  | one-cycle result: CDB (load), ROB (store) or misalign trap
// ST_DRAIN | flushed load still outstanding; swallow its mem_done
module ls_unit
  import ls_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 4,
  parameter int NAME_W = 5,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              ls_valid,
  output logic              ls_ready,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  input  logic [XLEN-1:0]   imm,
  input  logic [TAG_W-1:0]  op_tag,
  input  logic [NAME_W-1:0] op_name,
  input  logic [OP_W-1:0]   op_code,
  input  logic              mem_free,
  input  logic              mem_done,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [XLEN-1:0]   mem_addr,
  output logic [1:0]        mem_len,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              cdb_en,
  output logic [XLEN-1:0]   cdb_data,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [NAME_W-1:0] cdb_name,
  output logic              rob_en,
  output logic [TAG_W-1:0]  rob_tag
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misalign_en,
  output logic [TAG_W-1:0]  misalign_tag
`endif
);

  ls_state_e         state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [NAME_W-1:0] name_q, name_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              kill_q, kill_d;
  logic              mis_q, mis_d;

  logic              accept;
  logic [XLEN-1:0]   addr_sum;
  logic [1:0]        in_len;
  logic              in_misaligned;
  logic              is_store_q;
  logic [1:0]        len_q;
  logic [XLEN-1:0]   load_ext;
  logic [XLEN-1:0]   store_masked;
  logic              resp_ok;

  assign accept     = ls_valid && ls_ready;
  assign addr_sum   = op_a + imm;
  assign in_len     = acc_len(op_code[OP_ST_BIT], op_code[2:0]);
  assign is_store_q = op_q[OP_ST_BIT];
  assign len_q      = acc_len(is_store_q, op_q[2:0]);

`ifdef MISALIGN_TRAP_EN
  assign in_misaligned = ((in_len == LEN_H) && addr_sum[0]) ||
                         ((in_len == LEN_W) && (addr_sum[1:0] != 2'b00));
`else
  assign in_misaligned = 1'b0;
`endif

  ls_unit_extend #(.XLEN(XLEN)) u_load_ext (
    .funct3 (op_q[2:0]),
    .raw    (rdata_q),
    .result (load_ext)
  );

  // Store data masking reuses the extender with the zero-extending variant.
  ls_unit_extend #(.XLEN(XLEN)) u_store_mask (
    .funct3 (len_to_zext(len_q)),
    .raw    (wdata_q),
    .result (store_masked)
  );

  // Register the FSM state and the latched op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      tag_q   <= '0;
      name_q  <= '0;
      op_q    <= '0;
      kill_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      tag_q   <= tag_d;
      name_q  <= name_d;
      op_q    <= op_d;
      kill_q  <= kill_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state logic, op latching and flush handling
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    tag_d   = tag_q;
    name_d  = name_q;
    op_d    = op_q;
    kill_d  = kill_q;
    mis_d   = mis_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = addr_sum;
          wdata_d = op_b;
          tag_d   = op_tag;
          name_d  = op_name;
          op_d    = op_code;
          kill_d  = 1'b0;
          mis_d   = in_misaligned;
          state_d = in_misaligned ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (clear)         state_d = ST_IDLE;
        else if (mem_free) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A flushed store still finishes on the bus but never reports;
        // a flushed load is handed to DRAIN unless it completes right now.
        if (clear && is_store_q) kill_d = 1'b1;
        if (mem_done) begin
          rdata_d = mem_rdata;
          state_d = (clear && !is_store_q) ? ST_IDLE : ST_RESP;
        end else if (clear && !is_store_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (mem_done) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output strobes; data buses are zero whenever their strobe is low
  always_comb begin
    ls_ready  = (state_q == ST_IDLE) && !clear;
    mem_en    = (state_q == ST_REQ) && mem_free && !clear;
    mem_wr    = mem_en && is_store_q;
    mem_addr  = mem_en ? addr_q : '0;
    mem_len   = mem_en ? len_q : 2'd0;
    mem_wdata = (mem_en && is_store_q) ? store_masked : '0;
    resp_ok   = (state_q == ST_RESP) && !clear && !kill_q && !mis_q;
    cdb_en    = resp_ok && !is_store_q;
    cdb_data  = cdb_en ? load_ext : '0;
    cdb_tag   = cdb_en ? tag_q : '0;
    cdb_name  = cdb_en ? name_q : '0;
    rob_en    = resp_ok && is_store_q;
    rob_tag   = rob_en ? tag_q : '0;
  end

`ifdef MISALIGN_TRAP_EN
  // Misalignment trap pulse replaces the normal result in RESP
  always_comb begin
    misalign_en  = (state_q == ST_RESP) && !clear && mis_q;
    misalign_tag = misalign_en ? tag_q : '0;
  end
`endif

endmodule

// File: tb/tb_ls_unit.sv
// Directed testbench for ls_unit: loads/stores of each width, memory
// back-pressure, flush in REQ/WAIT, async reset and (if built) misalign trap.
module tb_ls_unit;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        ls_valid;
  logic        ls_ready;
  logic [31:0] op_a, op_b, imm;
  logic [3:0]  op_tag;
  logic [4:0]  op_name;
  logic [3:0]  op_code;
  logic        mem_free, mem_done;
  logic [31:0] mem_rdata;
  logic        mem_en, mem_wr;
  logic [31:0] mem_addr;
  logic [1:0]  mem_len;
  logic [31:0] mem_wdata;
  logic        cdb_en;
  logic [31:0] cdb_data;
  logic [3:0]  cdb_tag;
  logic [4:0]  cdb_name;
  logic        rob_en;
  logic [3:0]  rob_tag;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_en;
  logic [3:0]  misalign_tag;
`endif

  int n_chk = 0;
  int n_err = 0;

  ls_unit dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .ls_valid  (ls_valid),
    .ls_ready  (ls_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .imm       (imm),
    .op_tag    (op_tag),
    .op_name   (op_name),
    .op_code   (op_code),
    .mem_free  (mem_free),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_len   (mem_len),
    .mem_wdata (mem_wdata),
    .cdb_en    (cdb_en),
    .cdb_data  (cdb_data),
    .cdb_tag   (cdb_tag),
    .cdb_name  (cdb_name),
    .rob_en    (rob_en),
    .rob_tag   (rob_tag)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_en  (misalign_en),
    .misalign_tag (misalign_tag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Full op from accept to return to IDLE, with 'hold' cycles of mem_free low.
  task automatic run_op(input string nm_s, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                        input logic [3:0] tg, input logic [4:0] nm, input logic [31:0] rd,
                        input int hold, input logic [31:0] e_addr, input logic [1:0] e_len,
                        input logic [31:0] e_wdata, input logic [31:0] e_res);
    logic st;
    st = op[3];
    ls_valid = 1'b1; op_code = op; op_a = a; op_b = b; imm = im;
    op_tag = tg; op_name = nm; mem_free = (hold == 0);
    #1 chk({nm_s, "_ready"}, ls_ready, 1);
    cyc();
    ls_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      #1 chk({nm_s, "_holdoff"}, mem_en, 0);
      cyc();
    end
    mem_free = 1'b1;
    #1;
    chk({nm_s, "_mem_en"},    mem_en, 1);
    chk({nm_s, "_mem_wr"},    mem_wr, st);
    chk({nm_s, "_mem_addr"},  mem_addr, e_addr);
    chk({nm_s, "_mem_len"},   mem_len, e_len);
    chk({nm_s, "_mem_wdata"}, mem_wdata, e_wdata);
    cyc();
    mem_done = 1'b1; mem_rdata = rd;
    #1 chk({nm_s, "_one_pulse"}, mem_en, 0);
    chk({nm_s, "_no_early_resp"}, cdb_en | rob_en, 0);
    cyc();
    mem_done = 1'b0; mem_rdata = '0;
    #1;
    if (!st) begin
      chk({nm_s, "_cdb_en"},   cdb_en, 1);
      chk({nm_s, "_cdb_data"}, cdb_data, e_res);
      chk({nm_s, "_cdb_tag"},  cdb_tag, tg);
      chk({nm_s, "_cdb_name"}, cdb_name, nm);
      chk({nm_s, "_rob_off"},  rob_en, 0);
    end else begin
      chk({nm_s, "_rob_en"},  rob_en, 1);
      chk({nm_s, "_rob_tag"}, rob_tag, tg);
      chk({nm_s, "_cdb_off"}, cdb_en, 0);
    end
    cyc();
    #1;
    chk({nm_s, "_end_pulse"}, cdb_en | rob_en, 0);
    chk({nm_s, "_end_ready"}, ls_ready, 1);
    mem_free = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; ls_valid = 1'b0;
    op_a = '0; op_b = '0; imm = '0; op_tag = '0; op_name = '0; op_code = '0;
    mem_free = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_ready",  ls_ready, 1);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_cdb_en", cdb_en, 0);
    chk("rst_rob_en", rob_en, 0);
    chk("rst_addr",   mem_addr, 0);
    rst = 1'b0;
    cyc();

    //      name    op       a            b            imm          tag   name   rdata        hold addr         len   wdata        result
    run_op("lb",    4'b0000, 32'h100,     32'h0,       32'h4,       4'd3, 5'd5,  32'h000000F0, 0, 32'h104,     2'd0, 32'h0,       32'hFFFFFFF0);
    run_op("lhu",   4'b0101, 32'h200,     32'h0,       32'h2,       4'd4, 5'd6,  32'h0000ABCD, 0, 32'h202,     2'd1, 32'h0,       32'h0000ABCD);
    run_op("lh",    4'b0001, 32'h200,     32'h0,       32'h2,       4'd5, 5'd7,  32'h0000ABCD, 0, 32'h202,     2'd1, 32'h0,       32'hFFFFABCD);
    run_op("lw",    4'b0010, 32'h300,     32'h0,       32'hFFFFFFFC, 4'd6, 5'd8, 32'h12345678, 1, 32'h2FC,     2'd3, 32'h0,       32'h12345678);
    run_op("lbu",   4'b0100, 32'h10,      32'h0,       32'h7,       4'd7, 5'd9,  32'h12345680, 0, 32'h17,      2'd0, 32'h0,       32'h00000080);
    run_op("lundef",4'b0011, 32'h20,      32'h0,       32'h0,       4'd8, 5'd10, 32'h89ABCDEF, 0, 32'h20,      2'd3, 32'h0,       32'h89ABCDEF);
    run_op("sw",    4'b1010, 32'h400,     32'hDEADBEEF, 32'h8,      4'd9, 5'd0,  32'h0,        3, 32'h408,     2'd3, 32'hDEADBEEF, 32'h0);
    run_op("sb",    4'b1000, 32'h401,     32'hDEADBEEF, 32'h0,      4'd10, 5'd0, 32'h0,        0, 32'h401,     2'd0, 32'h000000EF, 32'h0);
    run_op("sh",    4'b1001, 32'h402,     32'hDEADBEEF, 32'h0,      4'd11, 5'd0, 32'h0,        0, 32'h402,     2'd1, 32'h0000BEEF, 32'h0);

    // mem_done coinciding with the strobe must not complete the op
    ls_valid = 1'b1; op_code = 4'b0010; op_a = 32'h40; imm = 32'h0; op_tag = 4'd12; op_name = 5'd12;
    mem_free = 1'b1;
    cyc();
    ls_valid = 1'b0; mem_done = 1'b1; mem_rdata = 32'hAAAA;
    #1 chk("early_done_strobe", mem_en, 1);
    cyc();
    mem_done = 1'b0;
    #1 chk("early_done_ignored", cdb_en, 0);
    cyc();
    #1 chk("early_done_still_wait", cdb_en, 0);
    mem_done = 1'b1; mem_rdata = 32'h11;
    cyc();
    mem_done = 1'b0;
    #1 chk("early_done_resp", cdb_en, 1);
    chk("early_done_data", cdb_data, 32'h11);
    cyc();
    mem_free = 1'b0;

    // clear in WAIT during a load: drain, no CDB
    ls_valid = 1'b1; op_code = 4'b0010; op_a = 32'h80; imm = 32'h0; op_tag = 4'd13; op_name = 5'd13;
    mem_free = 1'b1;
    cyc();
    ls_valid = 1'b0;
    cyc();
    clear = 1'b1;
    #1 chk("clr_ld_ready_wait", ls_ready, 0);
    cyc();
    clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("clr_ld_drain_ready", ls_ready, 0);
      chk("clr_ld_drain_cdb", cdb_en, 0);
      cyc();
    end
    mem_done = 1'b1; mem_rdata = 32'h55;
    #1 chk("clr_ld_done_ready", ls_ready, 0);
    cyc();
    mem_done = 1'b0;
    #1 chk("clr_ld_after_ready", ls_ready, 1);
    chk("clr_ld_after_cdb", cdb_en, 0);
    cyc();
    #1 chk("clr_ld_no_late_cdb", cdb_en, 0);

    // clear in WAIT during a store: completes on the bus, no rob_en
    ls_valid = 1'b1; op_code = 4'b1010; op_a = 32'h90; op_b = 32'h1; imm = 32'h0; op_tag = 4'd14;
    cyc();
    ls_valid = 1'b0;
    cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0; mem_done = 1'b1;
    #1 chk("clr_st_wait_ready", ls_ready, 0);
    cyc();
    mem_done = 1'b0;
    #1 chk("clr_st_rob_suppressed", rob_en, 0);
    chk("clr_st_resp_ready", ls_ready, 0);
    cyc();
    #1 chk("clr_st_end_ready", ls_ready, 1);
    mem_free = 1'b0;

    // clear in REQ: no strobe issued
    ls_valid = 1'b1; op_code = 4'b0010; op_a = 32'hA0; imm = 32'h0; op_tag = 4'd15;
    cyc();
    ls_valid = 1'b0; clear = 1'b1; mem_free = 1'b1;
    #1 chk("clr_req_no_strobe", mem_en, 0);
    chk("clr_req_ready", ls_ready, 0);
    cyc();
    clear = 1'b0;
    #1 chk("clr_req_idle_ready", ls_ready, 1);
    chk("clr_req_idle_strobe", mem_en, 0);
    mem_free = 1'b0;

    // async reset mid-REQ
    ls_valid = 1'b1; op_code = 4'b0010; op_a = 32'hB0; imm = 32'h0; op_tag = 4'd1;
    cyc();
    ls_valid = 1'b0;
    #1 chk("arst_in_req", ls_ready, 0);
    mem_free = 1'b1;
    #1 chk("arst_pre_strobe", mem_en, 1);
    rst = 1'b1;
    #1;
    chk("arst_mem_en",   mem_en, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_ready",    ls_ready, 1);
    chk("arst_cdb_rob",  cdb_en | rob_en, 0);
    cyc();
    rst = 1'b0;
    #1 chk("arst_stays_idle", mem_en, 0);
    mem_free = 1'b0;

`ifdef MISALIGN_TRAP_EN
    // misaligned LW traps without touching memory
    cyc();
    ls_valid = 1'b1; op_code = 4'b0010; op_a = 32'h100; imm = 32'h2; op_tag = 4'd6;
    mem_free = 1'b1;
    #1 chk("mis_accept_strobe", mem_en, 0);
    cyc();
    ls_valid = 1'b0;
    #1 chk("mis_en",      misalign_en, 1);
    chk("mis_tag",        misalign_tag, 4'd6);
    chk("mis_no_strobe",  mem_en, 0);
    chk("mis_no_cdb",     cdb_en, 0);
    cyc();
    #1 chk("mis_end",     misalign_en, 0);
    chk("mis_end_strobe", mem_en, 0);
    chk("mis_end_ready",  ls_ready, 1);
    mem_free = 1'b0;
`endif

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
